operand_fetch: RTL and testbench

//  Register-read stage between decode and execute. Drives the register file read addresses, tracks in-flight writers

---
 rtl/operand_fetch.sv | 152 +++++++++++++++
 tb/tb_operand_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: busy scoreboard, RAW/WAW stall and a one-entry valid/ready output register.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN forwards same-cycle writeback data to the operands.
module operand_fetch #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [AW-1:0]     rf_rs1,
  output logic [AW-1:0]     rf_rs2,
  input  logic [DATA_W-1:0] rf_q1,
  input  logic [DATA_W-1:0] rf_q2,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [AW-1:0]     out_rd,
  output logic              out_wen,
  output logic [CTRL_W-1:0] out_ctrl
);

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic [AW-1:0] X0 = {AW{1'b0}};

  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic hit1, hit2, hitd, rs1_ok, rs2_ok, waw, fire;
  logic [DATA_W-1:0] op1, op2;

  // A writeback to r this cycle releases r (x0 is never tracked).
  function automatic logic wb_hits(input logic en, input logic [AW-1:0] wr, input logic [AW-1:0] r);
    return en && (wr == r) && (r != X0);
  endfunction

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // Hazard detection and handshake.
  always_comb begin
    hit1     = wb_hits(wb_en, wb_rd, in_rs1);
    hit2     = wb_hits(wb_en, wb_rd, in_rs2);
    hitd     = wb_hits(wb_en, wb_rd, in_rd);
    rs1_ok   = (in_rs1 == X0) || !busy_q[in_rs1] || (BYPASS && hit1);
    rs2_ok   = (in_rs2 == X0) || !busy_q[in_rs2] || (BYPASS && hit2);
    waw      = in_wen && (in_rd != X0) && busy_q[in_rd] && !hitd;
    in_ready = !flush && (!out_valid_q || out_ready) && rs1_ok && rs2_ok && !waw;
    fire     = in_valid && in_ready;
  end

  // Operand selection: x0 reads zero, bypass beats the pre-write register file value.
  always_comb begin
    op1 = rf_q1;
    op2 = rf_q2;
    if (in_rs1 == X0) op1 = {DATA_W{1'b0}};
    else if (BYPASS && hit1) op1 = wb_data;
    else op1 = rf_q1;
    if (in_rs2 == X0) op2 = {DATA_W{1'b0}};
    else if (BYPASS && hit2) op2 = wb_data;
    else op2 = rf_q2;
  end

  // Scoreboard update; a new issue to rd wins over a release of the same rd.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (fire && in_wen && (in_rd == AW'(i))) busy_d[i] = 1'b1;
        else if (wb_en && (wb_rd == AW'(i))) busy_d[i] = 1'b0;
        else busy_d[i] = busy_q[i];
      end
      busy_d[0] = 1'b0;
    end
  end

  // Output pipeline register next state.
  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      op1_d       = op1;
      op2_d       = op2;
      rd_d        = in_rd;
      wen_d       = in_wen;
      ctrl_d      = in_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= {NREG{1'b0}};
      out_valid_q <= 1'b0;
      op1_q       <= {DATA_W{1'b0}};
      op2_q       <= {DATA_W{1'b0}};
      rd_q        <= X0;
      wen_q       <= 1'b0;
      ctrl_q      <= {CTRL_W{1'b0}};
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;
  assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic against a scoreboard model.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_wen, wb_en, flush, out_valid, out_ready, out_wen;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
  logic [31:0] in_ctrl, out_ctrl;
  logic [63:0] rf_q1, rf_q2, wb_data, out_op1, out_op2;

  logic [63:0] rf [32];
  bit          m_busy [32];
  bit          m_ov;
  logic [63:0] m_op1, m_op2;
  logic [4:0]  m_rd;
  logic        m_wen;
  logic [31:0] m_ctrl;
  int          n_checks = 0;
  int          n_fail = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_q1(rf_q1), .rf_q2(rf_q2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_wen(out_wen), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_ov = 1'b0; m_op1 = 64'd0; m_op2 = 64'd0; m_rd = 5'd0; m_wen = 1'b0; m_ctrl = 32'd0;
  endtask

  task automatic set_in(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic w);
    in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_wen = w; in_ctrl = $urandom;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r, input logic [63:0] data);
    wb_en = en; wb_rd = r; wb_data = data;
  endtask

  // One clock: check combinational outputs, predict, advance, check the registered bank.
  task automatic step();
    bit h1, h2, hd, ok1, ok2, waw, rdy, fire;
    logic [63:0] v1, v2;
    rf_q1 = rf[in_rs1];
    rf_q2 = rf[in_rs2];
    #1;
    h1  = wb_en && wb_rd == in_rs1 && in_rs1 != 5'd0;
    h2  = wb_en && wb_rd == in_rs2 && in_rs2 != 5'd0;
    hd  = wb_en && wb_rd == in_rd && in_rd != 5'd0;
    ok1 = in_rs1 == 5'd0 || !m_busy[in_rs1] || (BYP && h1);
    ok2 = in_rs2 == 5'd0 || !m_busy[in_rs2] || (BYP && h2);
    waw = in_wen && in_rd != 5'd0 && m_busy[in_rd] && !hd;
    rdy = !flush && (!m_ov || out_ready) && ok1 && ok2 && !waw;
    check_eq("in_ready", 64'(in_ready), 64'(rdy));
    check_eq("rf_rs1", 64'(rf_rs1), 64'(in_rs1));
    check_eq("rf_rs2", 64'(rf_rs2), 64'(in_rs2));
    fire = in_valid && rdy;
    v1 = (in_rs1 == 5'd0) ? 64'd0 : (BYP && h1) ? wb_data : rf[in_rs1];
    v2 = (in_rs2 == 5'd0) ? 64'd0 : (BYP && h2) ? wb_data : rf[in_rs2];
    @(posedge clk);
    if (flush) begin
      m_ov = 1'b0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wb_en && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
      if (fire) begin
        if (in_wen && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
        m_ov = 1'b1; m_op1 = v1; m_op2 = v2; m_rd = in_rd; m_wen = in_wen; m_ctrl = in_ctrl;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
    if (wb_en && wb_rd != 5'd0) rf[wb_rd] = wb_data;
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      check_eq("out_op1", out_op1, m_op1);
      check_eq("out_op2", out_op2, m_op2);
      check_eq("out_rd", 64'(out_rd), 64'(m_rd));
      check_eq("out_wen", 64'(out_wen), 64'(m_wen));
      check_eq("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    end
  endtask

  task automatic quiesce();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 64'd0);
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0] = 64'hDEAD;
    rf[5] = 64'hBAD5;
    quiesce();
    do_reset();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_op1", out_op1, 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);

    // RAW on r5 resolved by writeback 0x1234
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1); step();
    set_in(1'b1, 5'd5, 5'd0, 5'd9, 1'b0); step(); step();
    set_wb(1'b1, 5'd5, 64'h1234); step();
    set_wb(1'b0, 5'd0, 64'd0);
    if (BYP) begin
      check_eq("raw_bypass_valid", 64'(out_valid), 64'd1);
      check_eq("raw_bypass_op1", out_op1, 64'h1234);
    end else begin
      check_eq("raw_stall_valid", 64'(out_valid), 64'd0);
      step();
      check_eq("raw_rf_op1", out_op1, 64'h1234);
    end
    quiesce(); step(); step();

    // x0 sources read zero; rd=x0 never marks busy
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1); step();
    check_eq("x0_op1", out_op1, 64'd0);
    check_eq("x0_op2", out_op2, 64'd0);
    step(); step();
    quiesce(); step();

    // WAW on r7, then release and reissue r7 in the same cycle
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1); step(); step(); step();
    set_wb(1'b1, 5'd7, 64'h77); step();
    set_wb(1'b0, 5'd0, 64'd0); step();
    check_eq("waw_still_busy", 64'(in_ready), 64'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); set_wb(1'b1, 5'd7, 64'h78); step();
    quiesce(); step();

    // Backpressure for three cycles, then release
    set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b0); step();
    out_ready = 1'b0;
    set_in(1'b1, 5'd2, 5'd1, 5'd4, 1'b0); step(); step(); step();
    out_ready = 1'b1; step();
    check_eq("bp_release_rd", 64'(out_rd), 64'd4);
    quiesce(); step();

    // Flush with a held instruction and r3 busy
    set_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1); out_ready = 1'b0; step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b1;
    set_in(1'b1, 5'd3, 5'd0, 5'd8, 1'b0); step();
    check_eq("flush_then_fire_rd", 64'(out_rd), 64'd8);
    quiesce(); step();

    // Asynchronous reset mid-stream with out_valid=1 and r5 busy
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1); out_ready = 1'b0; step();
    set_in(1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    #2; reset = 1'b1; #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_busy5", 64'(in_ready), 64'd1);
    check_eq("async_rst_rd", 64'(out_rd), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    quiesce(); step();

    // Random traffic over a small register window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
